time_disp_scan: RTL and testbench

Display-side consumer of the clock's display-mode state. Takes the BCD hour/minute/second digits of the 24-hour counter plus the sequencer's `CURRENT_STATE_TIME` and `SEL_MODE1`. Selects the digit pair to show (MIN:SEC or HOUR:MIN) and time-multiplexes it onto a 4-digit common-anode 7-segment display. Also drives a blinking colon and blinks the edited field in set mode.

---
 rtl/time_disp_scan_pkg.sv | 24 ++
 rtl/time_disp_scan_seg7_dec.sv | 27 ++
 rtl/time_disp_scan.sv | 112 +++++++++++
 tb/tb_time_disp_scan.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/time_disp_scan_pkg.sv
// Shared display-mode constants and small helpers for the time display scanner.
// Latency: n/a (constants and pure functions only).
// Backpressure: none.
package time_disp_scan_pkg;

  // Display-mode codes driven by the clock sequencer; any other code shows MIN:SEC.
  localparam logic [1:0] MIN_SEC  = 2'b00;
  localparam logic [1:0] HOUR_MIN = 2'b01;

  // Active-low "everything off" patterns.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low one-hot anode enable for digit index d (AN[0] = rightmost).
  function automatic logic [3:0] an_sel(input logic [1:0] d);
    return ~(4'b0001 << d);
  endfunction

  // Fold the unused mode codes onto MIN_SEC.
  function automatic logic [1:0] mode_norm(input logic [1:0] m);
    return (m == HOUR_MIN) ? HOUR_MIN : MIN_SEC;
  endfunction

endpackage

// File: rtl/time_disp_scan_seg7_dec.sv
// BCD to 7-segment decoder, active-low outputs, blank for codes 10..15.
// Latency: purely combinational.
// Backpressure: none.
// Ports: bcd (4-bit digit in), seg (7-bit g..a out, 0 = segment lit).
module seg7_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/time_disp_scan.sv
// Multiplexes MIN:SEC or HOUR:MIN onto a 4-digit common-anode display with blinking colon/set field.
// Latency: AN/SEG registered, one cycle after the digit index and live inputs.
// Backpressure: none; free-running scan.
// Ports: CLK, RESET (sync, active-high), CURRENT_STATE_TIME (mode), SEL_MODE1 (set-mode blink),
//        HOUR10..SEC1 (BCD digits, used live), AN (active-low digit enables), SEG (active-low dp,g..a).
module time_disp_scan
  import time_disp_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] CURRENT_STATE_TIME,
  input  logic       SEL_MODE1,
  input  logic [3:0] HOUR10,
  input  logic [3:0] HOUR1,
  input  logic [3:0] MIN10,
  input  logic [3:0] MIN1,
  input  logic [3:0] SEC10,
  input  logic [3:0] SEC1,
  output logic [3:0] AN,
  output logic [7:0] SEG
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         dig;
  logic [1:0]         disp_mode;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;

  logic               slot_tick;
  logic               frame_tick;
  logic [3:0]         dig_bcd;
  logic [6:0]         dig_seg;
  logic               dp_on;
  logic               blank_on;
  logic [7:0]         seg_nxt;

  assign slot_tick  = (scan_cnt == SCAN_LAST);
  assign frame_tick = slot_tick && (dig == 2'd3);

  // Digit pair selection follows the frame-latched mode so a frame never mixes modes.
  always_comb begin
    dig_bcd = 4'h0;
    if (disp_mode == HOUR_MIN) begin
      case (dig)
        2'd3:    dig_bcd = HOUR10;
        2'd2:    dig_bcd = HOUR1;
        2'd1:    dig_bcd = MIN10;
        default: dig_bcd = MIN1;
      endcase
    end else begin
      case (dig)
        2'd3:    dig_bcd = MIN10;
        2'd2:    dig_bcd = MIN1;
        2'd1:    dig_bcd = SEC10;
        default: dig_bcd = SEC1;
      endcase
    end
  end

  seg7_dec u_dec (
    .bcd (dig_bcd),
    .seg (dig_seg)
  );

  // Colon is the dp of digit 2; the upper pair (digits 3/2) blanks in set mode off-phase.
  always_comb begin
    dp_on    = (dig == 2'd2) && blink_phase;
    blank_on = SEL_MODE1 && !blink_phase && dig[1];
    seg_nxt  = blank_on ? SEG_OFF : {~dp_on, dig_seg};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt    <= '0;
      dig         <= 2'd0;
      disp_mode   <= MIN_SEC;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      AN          <= AN_OFF;
      SEG         <= SEG_OFF;
    end else begin
      if (slot_tick) begin
        scan_cnt <= '0;
        dig      <= dig + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (frame_tick) begin
        disp_mode <= mode_norm(CURRENT_STATE_TIME);
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      AN  <= an_sel(dig);
      SEG <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_time_disp_scan.sv
// Directed bench for time_disp_scan with SCAN_DIV=4, BLINK_FRAMES=2, time 12:34:56.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: none.
module tb_time_disp_scan;

  logic       CLK;
  logic       RESET;
  logic [1:0] CURRENT_STATE_TIME;
  logic       SEL_MODE1;
  logic [3:0] HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1;
  logic [3:0] AN;
  logic [7:0] SEG;

  int n_checks;
  int n_fail;

  // Active-low patterns, dp off unless noted.
  localparam logic [7:0] S1   = 8'hF9;
  localparam logic [7:0] S2   = 8'hA4;
  localparam logic [7:0] S2DP = 8'h24;
  localparam logic [7:0] S3   = 8'hB0;
  localparam logic [7:0] S4   = 8'h99;
  localparam logic [7:0] S4DP = 8'h19;
  localparam logic [7:0] S5   = 8'h92;
  localparam logic [7:0] S6   = 8'h82;
  localparam logic [7:0] OFF  = 8'hFF;

  time_disp_scan #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .CURRENT_STATE_TIME (CURRENT_STATE_TIME),
    .SEL_MODE1          (SEL_MODE1),
    .HOUR10             (HOUR10),
    .HOUR1              (HOUR1),
    .MIN10              (MIN10),
    .MIN1               (MIN1),
    .SEC10              (SEC10),
    .SEC1               (SEC1),
    .AN                 (AN),
    .SEG                (SEG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One digit slot: AN and SEG must hold for all 4 cycles.
  task automatic slot(input string tag, input logic [3:0] an, input logic [7:0] seg);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s an c%0d", tag, i), {4'h0, AN}, {4'h0, an});
      chk($sformatf("%s seg c%0d", tag, i), SEG, seg);
      @(negedge CLK);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    slot({tag, " d0"}, 4'b1110, s0);
    slot({tag, " d1"}, 4'b1101, s1);
    slot({tag, " d2"}, 4'b1011, s2);
    slot({tag, " d3"}, 4'b0111, s3);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET = 1'b1;
    CURRENT_STATE_TIME = 2'b00;
    SEL_MODE1 = 1'b0;
    HOUR10 = 4'd1; HOUR1 = 4'd2;
    MIN10  = 4'd3; MIN1  = 4'd4;
    SEC10  = 4'd5; SEC1  = 4'd6;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("rst an %0d", i), {4'h0, AN}, 8'h0F);
      chk($sformatf("rst seg %0d", i), SEG, OFF);
    end
    RESET = 1'b0;
    @(negedge CLK);
    chk("post-rst seg6..0", {1'b0, SEG[6:0]}, 8'h02);

    // MIN:SEC scan, colon off for two frames then on for two.
    frame("f0", S6, S5, S4, S3);
    frame("f1", S6, S5, S4, S3);
    frame("f2", S6, S5, S4DP, S3);

    // Mode switch during digit 1: current frame unchanged, next frame HOUR:MIN.
    slot("f3 d0", 4'b1110, S6);
    CURRENT_STATE_TIME = 2'b01;
    slot("f3 d1", 4'b1101, S5);
    slot("f3 d2", 4'b1011, S4DP);
    slot("f3 d3", 4'b0111, S3);
    frame("f4", S4, S3, S2, S1);

    // Set-mode blink on the upper pair.
    SEL_MODE1 = 1'b1;
    frame("f5", S4, S3, OFF, OFF);
    frame("f6", S4, S3, S2DP, S1);
    frame("f7", S4, S3, S2DP, S1);
    frame("f8", S4, S3, OFF, OFF);

    // Unused mode code and an out-of-range BCD digit.
    CURRENT_STATE_TIME = 2'b11;
    SEC1 = 4'hA;
    frame("f9", S4, S3, OFF, OFF);
    SEL_MODE1 = 1'b0;
    slot("f10 d0", 4'b1110, OFF);
    slot("f10 d1", 4'b1101, S5);
    slot("f10 d2", 4'b1011, S4DP);
    SEC1 = 4'd6;
    slot("f10 d3", 4'b0111, S3);

    // Reset mid-frame at digit 2 with colon phase 1.
    slot("f11 d0", 4'b1110, S6);
    slot("f11 d1", 4'b1101, S5);
    chk("f11 d2 an", {4'h0, AN}, 8'h0B);
    chk("f11 d2 seg", SEG, S4DP);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst an", {4'h0, AN}, 8'h0F);
    chk("midrst seg", SEG, OFF);
    RESET = 1'b0;
    @(negedge CLK);
    frame("r0", S6, S5, S4, S3);
    frame("r1", S6, S5, S4, S3);
    frame("r2", S6, S5, S4DP, S3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
